// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data memory access, redirect resolution, MEM/WB register
module mem_stage #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemToReg_in,
  input  logic        Jal_in,
  input  logic        Zero_in,
  input  logic        Branch_in,
  input  logic [1:0]  MemRead_in,
  input  logic [1:0]  MemWrite_in,
  input  logic [1:0]  RegWrite_in,
  input  logic [1:0]  PCSrc_in,
  input  logic [4:0]  RegWriteAddress_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] ReadData1_in,
  input  logic [31:0] PCAdderOut_in,
  input  logic [31:0] JumpOutput_in,
  input  logic [31:0] BranchAdderOut_in,
  output logic        PCRedirect_out,
  output logic [31:0] PCTarget_out,
  output logic        Flush_out,
  output logic        MemToReg_out,
  output logic        Jal_out,
  output logic [1:0]  RegWrite_out,
  output logic [4:0]  RegWriteAddress_out,
  output logic [31:0] ALUResult_out,
  output logic [31:0] MemData_out,
  output logic [31:0] PCAdderOut_out,
  output logic        AlignFault_out
);

  logic [31:0]   r_mem [MEM_WORDS];

  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic [1:0]    w_size;
  logic          w_is_store;
  logic          w_is_load;
  logic          w_misaligned;
  logic          w_do_store;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rword;
  logic [31:0]   w_load_data;
  logic          w_redirect;
  logic [31:0]   w_target;
  logic          w_unused;

  assign w_idx      = ALUResult_in[AW+1:2];
  assign w_off      = ALUResult_in[1:0];
  assign w_unused   = ^ALUResult_in[31:AW+2];
  // A combined read+write is a store; the store's size governs alignment.
  assign w_is_store = |MemWrite_in;
  assign w_is_load  = |MemRead_in & ~w_is_store;
  assign w_size     = w_is_store ? MemWrite_in : MemRead_in;

  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b0000;
    w_wdata      = ReadData2_in;
    case (w_size)
      2'b01: begin
        w_misaligned = |w_off;
        w_be         = 4'b1111;
      end
      2'b10: begin
        w_misaligned = w_off[0];
        w_be         = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{ReadData2_in[15:0]}};
      end
      2'b11: begin
        w_be         = 4'b0001 << w_off;
        w_wdata      = {4{ReadData2_in[7:0]}};
      end
      default: ;
    endcase
  end

  assign w_do_store = w_is_store & ~w_misaligned & ~reset;

  always_ff @(posedge clk) begin
    if (w_do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign w_rword = r_mem[w_idx];

  always_comb begin
    w_load_data = 32'h0;
    if (w_is_load && !w_misaligned) begin
      case (w_size)
        2'b01:   w_load_data = w_rword;
        2'b10:   w_load_data = {{16{w_rword[16*w_off[1] + 15]}}, w_rword[16*w_off[1] +: 16]};
        2'b11:   w_load_data = {{24{w_rword[8*w_off + 7]}}, w_rword[8*w_off +: 8]};
        default: w_load_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    w_redirect = 1'b0;
    w_target   = PCAdderOut_in;
    case (PCSrc_in)
      2'b01: begin
        w_redirect = Branch_in & Zero_in;
        w_target   = BranchAdderOut_in;
      end
      2'b10: begin
        w_redirect = 1'b1;
        w_target   = JumpOutput_in;
      end
      2'b11: begin
        w_redirect = 1'b1;
        w_target   = ReadData1_in;
      end
      default: ;
    endcase
  end

  assign PCRedirect_out = w_redirect & ~reset;
  assign Flush_out      = PCRedirect_out;
  assign PCTarget_out   = PCRedirect_out ? w_target : PCAdderOut_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemToReg_out        <= 1'b0;
      Jal_out             <= 1'b0;
      RegWrite_out        <= 2'b00;
      RegWriteAddress_out <= 5'd0;
      ALUResult_out       <= 32'h0;
      MemData_out         <= 32'h0;
      PCAdderOut_out      <= 32'h0;
      AlignFault_out      <= 1'b0;
    end else begin
      MemToReg_out        <= MemToReg_in;
      Jal_out             <= Jal_in;
      RegWrite_out        <= RegWrite_in;
      RegWriteAddress_out <= RegWriteAddress_in;
      ALUResult_out       <= ALUResult_in;
      MemData_out         <= w_load_data;
      PCAdderOut_out      <= PCAdderOut_in;
      AlignFault_out      <= (w_is_store | w_is_load) & w_misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        MemToReg_in, Jal_in, Zero_in, Branch_in;
  logic [1:0]  MemRead_in, MemWrite_in, RegWrite_in, PCSrc_in;
  logic [4:0]  RegWriteAddress_in;
  logic [31:0] ALUResult_in, ReadData2_in, ReadData1_in, PCAdderOut_in, JumpOutput_in, BranchAdderOut_in;
  logic        PCRedirect_out, Flush_out, MemToReg_out, Jal_out, AlignFault_out;
  logic [31:0] PCTarget_out, ALUResult_out, MemData_out, PCAdderOut_out;
  logic [1:0]  RegWrite_out;
  logic [4:0]  RegWriteAddress_out;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] mdata;
    logic        fault;
    logic [1:0]  rw;
    logic [4:0]  ra;
    logic        jal;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] pca;
  } exp_t;
  exp_t sb_q[$];

  mem_stage dut (
    .clk(clk), .reset(reset),
    .MemToReg_in(MemToReg_in), .Jal_in(Jal_in), .Zero_in(Zero_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in), .PCSrc_in(PCSrc_in),
    .RegWriteAddress_in(RegWriteAddress_in), .ALUResult_in(ALUResult_in), .ReadData2_in(ReadData2_in),
    .ReadData1_in(ReadData1_in), .PCAdderOut_in(PCAdderOut_in), .JumpOutput_in(JumpOutput_in),
    .BranchAdderOut_in(BranchAdderOut_in),
    .PCRedirect_out(PCRedirect_out), .PCTarget_out(PCTarget_out), .Flush_out(Flush_out),
    .MemToReg_out(MemToReg_out), .Jal_out(Jal_out), .RegWrite_out(RegWrite_out),
    .RegWriteAddress_out(RegWriteAddress_out), .ALUResult_out(ALUResult_out),
    .MemData_out(MemData_out), .PCAdderOut_out(PCAdderOut_out), .AlignFault_out(AlignFault_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic compare_next();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("mdata", MemData_out, e.mdata);
    check("fault", {31'd0, AlignFault_out}, {31'd0, e.fault});
    check("pt_ctl", {24'd0, RegWrite_out, RegWriteAddress_out, Jal_out},
          {24'd0, e.rw, e.ra, e.jal});
    check("pt_m2r", {31'd0, MemToReg_out}, {31'd0, e.m2r});
    check("pt_alu", ALUResult_out, e.alu);
    check("pt_pca", PCAdderOut_out, e.pca);
  endtask

  // Drive one EX/MEM beat (called just after a rising edge), then compare after the capturing edge.
  task automatic access(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_fault);
    exp_t e;
    MemRead_in         = rd;
    MemWrite_in        = wr;
    ALUResult_in       = addr;
    ReadData2_in       = wdata;
    RegWrite_in        = 2'($urandom);
    RegWriteAddress_in = 5'($urandom);
    Jal_in             = 1'($urandom);
    MemToReg_in        = 1'($urandom);
    PCAdderOut_in      = $urandom;
    e.mdata = exp_data; e.fault = exp_fault; e.rw = RegWrite_in; e.ra = RegWriteAddress_in;
    e.jal = Jal_in; e.m2r = MemToReg_in; e.alu = addr; e.pca = PCAdderOut_in;
    sb_q.push_back(e);
    @(posedge clk); #1;
    compare_next();
  endtask

  initial begin
    reset = 1'b1;
    {MemToReg_in, Jal_in, Zero_in, Branch_in} = '0;
    {MemRead_in, MemWrite_in, RegWrite_in, PCSrc_in} = '0;
    RegWriteAddress_in = '0;
    {ALUResult_in, ReadData2_in, ReadData1_in, PCAdderOut_in, JumpOutput_in, BranchAdderOut_in} = '0;
    PCSrc_in = 2'b10; JumpOutput_in = 32'h88;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mdata", MemData_out, 32'h0);
    check("rst_alu", ALUResult_out, 32'h0);
    check("rst_redir", {31'd0, PCRedirect_out}, 32'd0);
    PCSrc_in = 2'b00;
    reset = 1'b0;

    access(2'b00, 2'b01, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access(2'b01, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    access(2'b00, 2'b11, 32'h13, 32'h12345680, 32'h0, 1'b0);
    access(2'b11, 2'b00, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    access(2'b01, 2'b00, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    access(2'b10, 2'b00, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    access(2'b00, 2'b10, 32'h11, 32'h1234, 32'h0, 1'b1);
    access(2'b01, 2'b00, 32'h12, 32'h0, 32'h0, 1'b1);
    access(2'b01, 2'b00, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    access(2'b10, 2'b00, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0);
    access(2'b11, 2'b00, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);
    access(2'b00, 2'b10, 32'h12, 32'hAAAA7001, 32'h0, 1'b0);
    access(2'b10, 2'b00, 32'h12, 32'h0, 32'h00007001, 1'b0);
    access(2'b01, 2'b00, 32'h1010, 32'h0, 32'h7001BEEF, 1'b0);
    access(2'b01, 2'b11, 32'h10, 32'h55, 32'h0, 1'b0);
    access(2'b01, 2'b00, 32'h10, 32'h0, 32'h7001BE55, 1'b0);
    access(2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 1'b0);
    access(2'b00, 2'b01, 32'h20, 32'h11111111, 32'h0, 1'b0);
    access(2'b01, 2'b00, 32'h20, 32'h0, 32'h11111111, 1'b0);

    // Explicit passthrough values.
    MemRead_in = 2'b00; MemWrite_in = 2'b00;
    RegWrite_in = 2'b01; RegWriteAddress_in = 5'd31; Jal_in = 1'b1; PCAdderOut_in = 32'h24;
    @(posedge clk); #1;
    check("pass_ctl", {24'd0, RegWrite_out, RegWriteAddress_out, Jal_out}, {24'd0, 2'b01, 5'd31, 1'b1});
    check("pass_pca", PCAdderOut_out, 32'h24);

    // Redirects are combinational.
    PCAdderOut_in = 32'h2C; BranchAdderOut_in = 32'h40; JumpOutput_in = 32'h300; ReadData1_in = 32'h1000;
    PCSrc_in = 2'b01; Branch_in = 1'b1; Zero_in = 1'b1; #1;
    check("br_taken", {30'd0, PCRedirect_out, Flush_out}, 32'd3);
    check("br_target", PCTarget_out, 32'h40);
    Zero_in = 1'b0; #1;
    check("br_not", {30'd0, PCRedirect_out, Flush_out}, 32'd0);
    check("br_not_tgt", PCTarget_out, 32'h2C);
    Zero_in = 1'b1; Branch_in = 1'b0; #1;
    check("br_nobranch", {31'd0, PCRedirect_out}, 32'd0);
    PCSrc_in = 2'b10; #1;
    check("jmp_target", PCTarget_out, 32'h300);
    PCSrc_in = 2'b11; #1;
    check("jr_redir", {31'd0, PCRedirect_out}, 32'd1);
    check("jr_target", PCTarget_out, 32'h1000);
    PCSrc_in = 2'b00; #1;
    check("seq_target", {PCTarget_out[31:1], PCRedirect_out}, {31'h16, 1'b0});

    // Async reset during a store: no write, outputs clear before the next edge.
    @(posedge clk); #1;
    MemRead_in = 2'b01; MemWrite_in = 2'b00; ALUResult_in = 32'h20;
    @(posedge clk); #1;
    check("pre_rst_load", MemData_out, 32'h11111111);
    MemRead_in = 2'b00; MemWrite_in = 2'b01; ReadData2_in = 32'hFFFFFFFF; PCSrc_in = 2'b10;
    #2 reset = 1'b1;
    #1;
    check("arst_mdata", MemData_out, 32'h0);
    check("arst_ctl", {24'd0, RegWrite_out, RegWriteAddress_out, Jal_out}, 32'd0);
    check("arst_pca", PCAdderOut_out, 32'h0);
    check("arst_redir", {30'd0, PCRedirect_out, Flush_out}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    PCSrc_in = 2'b00; MemWrite_in = 2'b00; MemRead_in = 2'b01;
    @(posedge clk); #1;
    check("arst_nowrite", MemData_out, 32'h11111111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline. Consumes the EX/MEM pipeline outputs and performs data-memory loads and stores (word/half/byte, little-endian). Resolves branch, jump and jump-register redirects. Registers the writeback payload into the MEM/WB boundary for the writeback stage.

## Interface
Parameters:
- `MEM_WORDS`, default 1024: data memory depth in 32-bit words; must be a power of two.
- `AW`, default log2(`MEM_WORDS`): word-index width, derived.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high
- `MemToReg_in`, `Jal_in`, `Zero_in`, `Branch_in`  in  1 each  from EX/MEM
- `MemRead_in`, `MemWrite_in`  in  2 each  access size: 00 none, 01 word, 10 half, 11 byte
- `RegWrite_in`  in  2  writeback enable code, passed through
- `PCSrc_in`  in  2  00 sequential, 01 conditional branch, 10 jump, 11 jump-register
- `RegWriteAddress_in`  in  5  destination register
- `ALUResult_in`, `ReadData2_in`, `ReadData1_in`, `PCAdderOut_in`, `JumpOutput_in`, `BranchAdderOut_in`  in  32 each
- `PCRedirect_out`  out  1  combinational; fetch takes `PCTarget_out`
- `PCTarget_out`  out  32  combinational redirect target
- `Flush_out`  out  1  combinational; equals `PCRedirect_out`; kills IF/ID and ID/EX
- `MemToReg_out`, `Jal_out`  out  1 each  registered
- `RegWrite_out`  out  2  registered
- `RegWriteAddress_out`  out  5  registered
- `ALUResult_out`, `MemData_out`, `PCAdderOut_out`  out  32 each  registered
- `AlignFault_out`  out  1  registered; high for one cycle after a misaligned access

## Operation
- Address: byte address is `ALUResult_in[AW+1:0]`. Word index is `ALUResult_in[AW+1:2]`. Upper bits are ignored, so addresses wrap modulo the memory size.
- Alignment: word accesses require address bits [1:0]=00. Half accesses require bit 0 = 0. Byte accesses are always aligned.
- Misaligned access:
  - Store: suppressed; memory is unchanged.
  - Load: `MemData_out` = 0.
  - Either case: `AlignFault_out` = 1 in the following cycle. All other fields pass through unchanged.
- Store: on the rising `clk`, write lanes selected by size and offset, little-endian.
  - Byte: `ReadData2_in[7:0]` written to lane = addr[1:0].
  - Half: `ReadData2_in[15:0]` written to lanes addr[1]*2 and addr[1]*2+1.
  - Word: all four lanes.
  - Unselected lanes are preserved.
- Load: the array is read combinationally and the selected lane(s) are sign-extended to 32 bits, then registered into `MemData_out`. When `MemRead_in` = 00, `MemData_out` = 0.
- `MemRead_in` and `MemWrite_in` both nonzero: the access is treated as a store only; `MemData_out` = 0.
- Redirect (combinational on inputs):
  - `PCSrc_in`=01: redirect iff `Branch_in` & `Zero_in`; target = `BranchAdderOut_in`.
  - `PCSrc_in`=10: redirect to `JumpOutput_in`.
  - `PCSrc_in`=11: redirect to `ReadData1_in`.
  - `PCSrc_in`=00: no redirect.
  - No redirect: `PCTarget_out` = `PCAdderOut_in`.
- Reset:
  - While `reset` is high, `PCRedirect_out` and `Flush_out` are forced to 0 and no memory write occurs.
  - All registered outputs go to 0 immediately, asynchronously, and hold 0 until the first rising edge after deassertion.
  - Memory contents are not cleared by reset.

## Timing
- Store latency: data is visible to a load presented in the next cycle (store cycle N, load cycle N+1 returns new data).
- Load latency: one cycle; `MemData_out` is valid on the edge that also captures the rest of the MEM/WB payload.
- Redirect has zero latency: `PCRedirect_out`/`PCTarget_out` are valid in the same cycle the EX/MEM inputs are valid.
- `AlignFault_out` is a one-cycle pulse per faulting access. Back-to-back faults hold it high.
- Reset asserted mid-cycle during a store: the write is not performed at the next edge; outputs clear at once.
- Reset deasserted: the first edge captures the inputs normally.

## Test plan
- Word round trip: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> `MemData_out` = 0xDEADBEEF one cycle after the load; `AlignFault_out` = 0.
- Byte lanes: after the word round trip, store byte 0x80 at 0x13, then load byte at 0x13 -> 0xFFFFFF80. Then load word at 0x10 -> 0x80ADBEEF. Then load half at 0x10 -> 0xFFFFBEEF.
- Misalignment: store half 0x1234 at 0x11 -> memory word at 0x10 unchanged, `AlignFault_out` = 1 for one cycle. Then load word at 0x12 -> `MemData_out` = 0, `AlignFault_out` = 1.
- Redirects:
  - `PCSrc_in`=01, `Branch_in`=1, `Zero_in`=1, `BranchAdderOut_in`=0x40 -> `PCRedirect_out`=1, `Flush_out`=1, `PCTarget_out`=0x40.
  - Same with `Zero_in`=0 -> redirect 0, target = `PCAdderOut_in`.
  - `PCSrc_in`=11, `ReadData1_in`=0x1000 -> target 0x1000.
- Passthrough: `RegWrite_in`=01, `RegWriteAddress_in`=31, `Jal_in`=1, `PCAdderOut_in`=0x24 -> same values on the outputs one edge later.
- Async reset: assert `reset` mid-cycle while a word store of 0xFFFFFFFF at 0x20 is presented -> all registered outputs 0 before the next edge, redirect 0, and a later load at 0x20 returns the prior contents.
